// File: rtl/alarm_annunciator.sv
// alarm_annunciator: turns the alarm controller's trigger status into entry delay, timed siren, ack/silence and status LED.
// Latency: outputs are registered; siren and alarm_event rise ENTRY_DELAY edges after the edge that first samples triggered.
// Backpressure: none; status and ack are sampled every cycle. Optional ALARM_EVENT_COUNT_EN adds the event_count port.
module alarm_annunciator #(
  parameter int ENTRY_DELAY  = 8,
  parameter int SIREN_CYCLES = 32,
  parameter int BLINK_HALF   = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             disarmed_i,
  input  logic             armed_i,
  input  logic             triggered_i,
  input  logic             ack,
  output logic             siren,
  output logic             led,
  output logic             alarm_event,
  output logic             busy,
  output logic             status_err
`ifdef ALARM_EVENT_COUNT_EN
  ,
  output logic [CNT_W-1:0] event_count
`endif
);

  localparam int TMAX = (ENTRY_DELAY > SIREN_CYCLES) ? ENTRY_DELAY : SIREN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
  localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    SOUNDING = 2'd2,
    SILENCED = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [BW-1:0] blink, blink_nxt;
  logic          led_nxt;
  logic          event_nxt;

  logic [2:0] status;
  logic       st_trig;
  logic       st_armed;
  logic       st_invalid;

  assign status = {disarmed_i, armed_i, triggered_i};

  // Decode the controller status; anything outside the three legal codes counts as disarmed.
  always_comb begin
    st_trig    = (status == 3'b011);
    st_armed   = (status == 3'b010);
    st_invalid = !((status == 3'b100) || (status == 3'b010) || (status == 3'b011));
  end

  // State and timer register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next state: trigger loss beats ack, ack beats timer expiry.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    event_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (st_trig) begin
          state_nxt = ENTRY;
          timer_nxt = ENTRY_LOAD;
        end
      end
      ENTRY: begin
        if (!st_trig || ack) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == '0) begin
          state_nxt = SOUNDING;
          timer_nxt = SIREN_LOAD;
          event_nxt = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      SOUNDING: begin
        if (!st_trig) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (ack || (timer == '0)) begin
          state_nxt = SILENCED;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      SILENCED: begin
        // Holding here while the trigger level persists keeps one trigger from sounding twice.
        if (!st_trig) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // LED for the state being entered; the blink phase restarts on every entry to ENTRY or SOUNDING.
  always_comb begin
    led_nxt   = led;
    blink_nxt = blink;
    case (state_nxt)
      ENTRY, SOUNDING: begin
        if (state_nxt != state) begin
          led_nxt   = 1'b1;
          blink_nxt = BLINK_LOAD;
        end else if (blink == '0) begin
          led_nxt   = ~led;
          blink_nxt = BLINK_LOAD;
        end else begin
          blink_nxt = blink - 1'b1;
        end
      end
      SILENCED: begin
        led_nxt   = 1'b1;
        blink_nxt = '0;
      end
      default: begin
        // Idle shows whether the system is armed; a trigger aborted by ack still counts as armed.
        led_nxt   = st_armed || st_trig;
        blink_nxt = '0;
      end
    endcase
  end

  // Registered user-facing outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      siren       <= 1'b0;
      led         <= 1'b0;
      alarm_event <= 1'b0;
      busy        <= 1'b0;
      status_err  <= 1'b0;
      blink       <= '0;
    end else begin
      siren       <= (state_nxt == SOUNDING);
      led         <= led_nxt;
      alarm_event <= event_nxt;
      busy        <= (state_nxt != IDLE);
      status_err  <= st_invalid;
      blink       <= blink_nxt;
    end
  end

`ifdef ALARM_EVENT_COUNT_EN
  // Saturating count of siren starts, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      event_count <= '0;
    end else if (event_nxt && (event_count != {CNT_W{1'b1}})) begin
      event_count <= event_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb_alarm_annunciator: table-driven vectors plus hand-written trigger sequences for alarm_annunciator.
// A second instance uses ENTRY_DELAY=1, SIREN_CYCLES=2, BLINK_HALF=1 to exercise the minimum parameters.
// Expected outputs are queued when inputs are driven and compared one edge later.
module tb_alarm_annunciator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, disarmed_i, armed_i, triggered_i, ack;
  logic siren, led, alarm_event, busy, status_err;
  logic siren1, led1, event1, busy1, err1;
`ifdef ALARM_EVENT_COUNT_EN
  logic [7:0] event_count, event_count1;
`endif

  alarm_annunciator #(.ENTRY_DELAY(8), .SIREN_CYCLES(32), .BLINK_HALF(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .disarmed_i(disarmed_i), .armed_i(armed_i),
    .triggered_i(triggered_i), .ack(ack), .siren(siren), .led(led),
    .alarm_event(alarm_event), .busy(busy), .status_err(status_err)
`ifdef ALARM_EVENT_COUNT_EN
    , .event_count(event_count)
`endif
  );

  alarm_annunciator #(.ENTRY_DELAY(1), .SIREN_CYCLES(2), .BLINK_HALF(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .disarmed_i(disarmed_i), .armed_i(armed_i),
    .triggered_i(triggered_i), .ack(ack), .siren(siren1), .led(led1),
    .alarm_event(event1), .busy(busy1), .status_err(err1)
`ifdef ALARM_EVENT_COUNT_EN
    , .event_count(event_count1)
`endif
  );

  // exp/msk order: {siren, led, alarm_event, busy, status_err}
  typedef struct packed {
    logic       rst_n;
    logic [2:0] st;
    logic       ack;
    logic [4:0] exp;
    logic [4:0] msk;
  } vec_t;

  // exp1 order for the minimum-parameter instance: {siren, led, alarm_event}
  typedef struct packed {
    logic [4:0] exp;
    logic [4:0] msk;
    logic       chk1;
    logic [2:0] exp1;
  } sb_t;

  sb_t   sbq[$];
  string nameq[$];
  int    tests = 0;
  int    fails = 0;
  vec_t  tbl[18];

  task automatic step(input logic r, input logic [2:0] st, input logic a,
                      input logic [4:0] e, input logic [4:0] m,
                      input logic c1, input logic [2:0] e1, input string nm);
    sb_t        it;
    string      n;
    logic [4:0] got;
    logic [2:0] got1;
    @(negedge clk);
    reset_n = r;
    {disarmed_i, armed_i, triggered_i} = st;
    ack = a;
    it.exp  = e;
    it.msk  = m;
    it.chk1 = c1;
    it.exp1 = e1;
    sbq.push_back(it);
    nameq.push_back(nm);
    @(posedge clk);
    #1;
    it  = sbq.pop_front();
    n   = nameq.pop_front();
    got = {siren, led, alarm_event, busy, status_err};
    tests++;
    if ((got & it.msk) !== (it.exp & it.msk)) begin
      fails++;
      $display("FAIL %s: got {siren,led,event,busy,err}=%b expected %b (care %b)", n, got, it.exp, it.msk);
    end
    if (it.chk1) begin
      got1 = {siren1, led1, event1};
      tests++;
      if (got1 !== it.exp1) begin
        fails++;
        $display("FAIL %s_min: got {siren,led,event}=%b expected %b", n, got1, it.exp1);
      end
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] st, input logic a);
    @(negedge clk);
    reset_n = r;
    {disarmed_i, armed_i, triggered_i} = st;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of the default instance k edges after the trigger was first sampled.
  function automatic logic [4:0] trig_exp(input int k);
    logic s, l, ev;
    s  = (k >= 8) && (k < 40);
    ev = (k == 8);
    if (k < 8)       l = ((k / 4) % 2) == 0;
    else if (k < 40) l = (((k - 8) / 4) % 2) == 0;
    else             l = 1'b1;
    return {s, l, ev, 1'b1, 1'b0};
  endfunction

  // Expected outputs of the minimum-parameter instance k edges after the trigger was first sampled.
  function automatic logic [2:0] trig_exp1(input int k);
    logic s, l, ev;
    s  = (k == 1) || (k == 2);
    ev = (k == 1);
    l  = (k != 2);
    return {s, l, ev};
  endfunction

  initial begin
    reset_n = 1'b0;
    {disarmed_i, armed_i, triggered_i} = 3'b100;
    ack = 1'b0;

    tbl[0]  = '{1'b0, 3'b011, 1'b0, 5'b00000, 5'b11111};
    tbl[1]  = '{1'b0, 3'b011, 1'b1, 5'b00000, 5'b11111};
    tbl[2]  = '{1'b1, 3'b100, 1'b0, 5'b00000, 5'b11111};
    tbl[3]  = '{1'b1, 3'b010, 1'b0, 5'b01000, 5'b11111};
    tbl[4]  = '{1'b1, 3'b010, 1'b1, 5'b01000, 5'b11111};
    tbl[5]  = '{1'b1, 3'b110, 1'b0, 5'b00001, 5'b11111};
    tbl[6]  = '{1'b1, 3'b000, 1'b0, 5'b00001, 5'b11111};
    tbl[7]  = '{1'b1, 3'b010, 1'b0, 5'b01000, 5'b11111};
    tbl[8]  = '{1'b1, 3'b111, 1'b0, 5'b00001, 5'b11111};
    tbl[9]  = '{1'b1, 3'b001, 1'b0, 5'b00001, 5'b11111};
    tbl[10] = '{1'b1, 3'b101, 1'b0, 5'b00001, 5'b11111};
    tbl[11] = '{1'b1, 3'b100, 1'b0, 5'b00000, 5'b11111};
    tbl[12] = '{1'b1, 3'b011, 1'b1, 5'b01010, 5'b11111};
    tbl[13] = '{1'b1, 3'b011, 1'b0, 5'b01010, 5'b11111};
    tbl[14] = '{1'b1, 3'b011, 1'b0, 5'b01010, 5'b11111};
    tbl[15] = '{1'b1, 3'b011, 1'b1, 5'b00000, 5'b10111};
    tbl[16] = '{1'b1, 3'b010, 1'b0, 5'b01000, 5'b11111};
    tbl[17] = '{1'b1, 3'b010, 1'b0, 5'b01000, 5'b11111};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst_n, tbl[i].st, tbl[i].ack, tbl[i].exp, tbl[i].msk, 1'b0, 3'b000,
           $sformatf("vec%0d", i));
    end

    // Full run: trigger held, both instances start from IDLE.
    for (int k = 0; k < 46; k++) begin
      step(1'b1, 3'b011, 1'b0, trig_exp(k), 5'b11111, (k < 6), trig_exp1(k),
           $sformatf("hold_k%0d", k));
    end
    step(1'b1, 3'b100, 1'b0, 5'b00000, 5'b11111, 1'b0, 3'b000, "hold_drop");

    // Ack during SOUNDING, trigger held afterwards, then re-trigger.
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 3'b011, 1'b0, trig_exp(k), 5'b11111, 1'b0, 3'b000, $sformatf("ackrun_k%0d", k));
    end
    step(1'b1, 3'b011, 1'b1, 5'b01010, 5'b11111, 1'b0, 3'b000, "ack_sounding");
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 3'b011, 1'b0, 5'b01010, 5'b11111, 1'b0, 3'b000, $sformatf("silenced_%0d", k));
    end
    step(1'b1, 3'b010, 1'b0, 5'b01000, 5'b11111, 1'b0, 3'b000, "silenced_disarm");
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 3'b011, 1'b0, trig_exp(k), 5'b11111, 1'b0, 3'b000, $sformatf("retrig_k%0d", k));
    end

    // Invalid status during SOUNDING.
    step(1'b1, 3'b110, 1'b0, 5'b00001, 5'b11111, 1'b0, 3'b000, "invalid_sounding");
    step(1'b1, 3'b010, 1'b0, 5'b01000, 5'b11111, 1'b0, 3'b000, "invalid_clear");

    // Ack together with trigger drop in ENTRY.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'b011, 1'b0, trig_exp(k), 5'b11111, 1'b0, 3'b000, $sformatf("drop_k%0d", k));
    end
    step(1'b1, 3'b010, 1'b1, 5'b01000, 5'b11111, 1'b0, 3'b000, "ack_and_drop");

    // Ack exactly at entry-delay expiry.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 3'b011, 1'b0, trig_exp(k), 5'b11111, 1'b0, 3'b000, $sformatf("expiry_k%0d", k));
    end
    step(1'b1, 3'b011, 1'b1, 5'b00000, 5'b10111, 1'b0, 3'b000, "ack_at_expiry");
    step(1'b1, 3'b010, 1'b0, 5'b01000, 5'b11111, 1'b0, 3'b000, "after_expiry_ack");

    // Reset while SOUNDING.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 3'b011, 1'b0, trig_exp(k), 5'b11111, 1'b0, 3'b000, $sformatf("prereset_k%0d", k));
    end
    step(1'b0, 3'b011, 1'b0, 5'b00000, 5'b11111, 1'b1, 3'b000, "reset_sounding");
    step(1'b1, 3'b010, 1'b0, 5'b01000, 5'b11111, 1'b0, 3'b000, "after_reset");

`ifdef ALARM_EVENT_COUNT_EN
    drive(1'b0, 3'b100, 1'b0);
    tests++;
    if (event_count !== 8'd0) begin
      fails++;
      $display("FAIL count_reset0: got %0d expected 0", event_count);
    end
    for (int r = 0; r < 260; r++) begin
      for (int k = 0; k < 9; k++) drive(1'b1, 3'b011, 1'b0);
      drive(1'b1, 3'b100, 1'b0);
      if (r == 0) begin
        tests++;
        if (event_count !== 8'd1) begin
          fails++;
          $display("FAIL count_first: got %0d expected 1", event_count);
        end
      end
    end
    tests++;
    if (event_count !== 8'd255) begin
      fails++;
      $display("FAIL count_saturate: got %0d expected 255", event_count);
    end
    for (int k = 0; k < 10; k++) drive(1'b1, 3'b011, 1'b0);
    drive(1'b1, 3'b100, 1'b0);
    tests++;
    if (event_count !== 8'd255) begin
      fails++;
      $display("FAIL count_hold: got %0d expected 255", event_count);
    end
    drive(1'b0, 3'b100, 1'b0);
    tests++;
    if (event_count !== 8'd0) begin
      fails++;
      $display("FAIL count_reset: got %0d expected 0", event_count);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
